// File: rtl/gcd_stein_top.sv
// ============================================================================
// gcd_stein_top
// ----------------------------------------------------------------------------
// Binary (Stein) GCD unit. Uses shifts and one subtractor, with no divider.
// A start in IDLE captures A and B. Each CALC cycle then applies one
// reduction rule. The result appears with a one-cycle done_sig pulse.
//
// If either operand is zero, the unit skips CALC and goes straight to DONE.
// It returns A|B there. zero_err is raised when both operands are zero.
//
// Parameters
//   op_sz   operand / result width (>= 2)
//   cnt_sz  cycle counter width (must hold 2*op_sz+1)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   request, sampled only in IDLE
//   A, B      in   operands, captured together with start
//   busy      out  registered, high in CALC and DONE
//   done_sig  out  one-cycle pulse while res/zero_err/cycles are fresh
//   res       out  gcd(A,B), held until the next completion
//   zero_err  out  both operands were zero
//   cycles    out  CALC cycles spent on the last operation
// ============================================================================
module gcd_stein_top #(
    parameter int op_sz  = 8,
    parameter int cnt_sz = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [op_sz-1:0]  A,
    input  logic [op_sz-1:0]  B,
    output logic              busy,
    output logic              done_sig,
    output logic [op_sz-1:0]  res,
    output logic              zero_err,
    output logic [cnt_sz-1:0] cycles
);

    // Width of k. It is large enough to count every common factor of two
    // that an op_sz-bit operand can hold.
    localparam int k_sz = $clog2(op_sz) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [op_sz-1:0]   a_q,        a_d;
    logic [op_sz-1:0]   b_q,        b_d;
    logic [k_sz-1:0]    k_q,        k_d;
    logic [cnt_sz-1:0]  cnt_q,      cnt_d;
    logic [op_sz-1:0]   res_q,      res_d;
    logic               zero_err_q, zero_err_d;
    logic [cnt_sz-1:0]  cycles_q,   cycles_d;
    logic               busy_q,     busy_d;

    // Saturating increment of the CALC cycle counter.
    logic [cnt_sz-1:0]  cnt_inc;
    assign cnt_inc = (cnt_q == {cnt_sz{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default before the case statement.
        // Any path that skips an assignment then holds the register value,
        // and no latch is inferred.
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        zero_err_d = zero_err_q;
        cycles_d   = cycles_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if ((A != '0) && (B != '0)) begin
                        a_d     = A;
                        b_d     = B;
                        k_d     = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        // gcd(x,0) = x. Both zero has no gcd, so flag it.
                        res_d      = A | B;
                        zero_err_d = (A == '0) && (B == '0);
                        cycles_d   = '0;
                        state_d    = DONE;
                    end
                end
            end

            CALC: begin
                cnt_d = cnt_inc;
                if (a_q == b_q) begin
                    // Restore the common powers of two removed by rule 2.
                    res_d      = a_q << k_q;
                    cycles_d   = cnt_inc;
                    zero_err_d = 1'b0;
                    state_d    = DONE;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 1'b1;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    // Odd minus odd is even, so the shift loses no bits.
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then update together from values sampled before the edge.
        if (rst) begin
            // NOTE: datapath registers are reset as well as control. A reset
            // mid-operation then leaves no stale result on the outputs.
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            res_q      <= '0;
            zero_err_q <= 1'b0;
            cycles_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            zero_err_q <= zero_err_d;
            cycles_q   <= cycles_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done_sig = (state_q == DONE);
    assign res      = res_q;
    assign zero_err = zero_err_q;
    assign cycles   = cycles_q;

endmodule

// File: doc/gcd_stein_top.md
# gcd_stein_top

Parametrised successor to the `gcd_top` GCD unit. It computes gcd(A,B) with the binary (Stein) algorithm: shifts and one subtractor, no divider. Compared with `gcd_top` it adds a busy indication, explicit zero-operand handling with an error flag, and a per-operation cycle count. It keeps the same start/done_sig handshake, so it can replace `gcd_top` in the same test environment.

## Interface
- op_sz, default 8: operand and result width, must be ≥ 2.
- cnt_sz, default 8: width of the cycle counter; must hold 2*op_sz+1.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- A  in  op_sz  operand, captured with start.
- B  in  op_sz  operand, captured with start.
- busy  out  1  high in CALC and DONE.
- done_sig  out  1  one-cycle pulse when res/zero_err/cycles are updated.
- res  out  op_sz  gcd result.
- zero_err  out  1  set when both operands are 0.
- cycles  out  cnt_sz  number of CALC cycles used by the last operation.

## Operation
- States: IDLE, CALC, DONE.
- Registers: a, b (op_sz bits), k (shift count, clog2(op_sz)+1 bits), cnt (cnt_sz bits).
- IDLE, start=1, both operands non-zero:
  - a←A, b←B, k←0, cnt←0.
  - Next state CALC.
- IDLE, start=1, A=0 or B=0:
  - res←A|B, zero_err←(A==0 && B==0), cycles←0.
  - Next state DONE directly; no CALC cycles.
- IDLE, start=0: stay in IDLE; outputs hold.
- CALC: every cycle increments cnt (saturating) and applies exactly one rule, highest priority first:
  1. a==b: res←a<<k, cycles←cnt+1, zero_err←0, next state DONE.
  2. a and b both even: a←a>>1, b←b>>1, k←k+1.
  3. a even: a←a>>1.
  4. b even: b←b>>1.
  5. a>b: a←(a−b)>>1.
  6. otherwise: b←(b−a)>>1.
- Rule 2 fires only before the first odd value appears; after that, at least one of a, b stays odd.
- a<<k never exceeds min(A,B), so res cannot overflow. The subtraction is unsigned op_sz bits and never underflows, because of the compare.
- DONE: done_sig=1 for this single cycle; next state IDLE unconditionally.
- start outside IDLE is ignored, including changes to A and B.
- If start is held high, a new capture happens on the first IDLE cycle after DONE, using the current A and B.

## Timing
- Reset values: state IDLE, busy 0, done_sig 0, res 0, zero_err 0, cycles 0, internal registers 0.
- Reset mid-operation: next edge returns to IDLE with all outputs at their reset values. No done_sig is generated and the result is discarded.
- Capture edge E0 (IDLE with start=1) moves to CALC. CALC lasts `cycles` edges. done_sig is high in the cycle after edge E0+cycles.
- Zero-operand case: done_sig is high in the cycle after E0.
- busy is registered: high from the cycle after E0 through the done_sig cycle, low in IDLE.
- res, zero_err and cycles:
  - update on the edge that enters DONE;
  - are valid while done_sig=1;
  - hold until the next entry into DONE.
- Throughput: one operation per cycles+2 clocks (capture, CALC×cycles, DONE). The zero-operand path takes 2 clocks.

## Test plan
- Reset, then A=60, B=48 → cycles=7, res=12, zero_err=0; done_sig high exactly one cycle; busy high 8 cycles.
- A=24, B=48 → cycles=5, res=24. A=10, B=10 → cycles=1, res=10.
- op_sz=8, A=255, B=1 → cycles=8, res=1.
- op_sz=16, A=65535, B=65535 → cycles=1, res=65535. A=40960, B=8192 → res=8192.
- A=0, B=7 → res=7, zero_err=0, cycles=0, done_sig in the cycle after capture. A=0, B=0 → res=0, zero_err=1.
- Overlap and reset:
  - Start 60/48; change A to 9 and pulse start during CALC → result is still 12.
  - Start 60/48 again; assert rst for one cycle at CALC cycle 3 → no done_sig; all outputs return to 0.
  - Then start 24/48 → res=24.
